// File: rtl/layer2_conv_engine.sv
// layer2_conv_engine: 3x3x8 valid convolution over the pooled 14x14x8 maps.
// Ports: clk/rst, start/busy/done, pooled-memory read (load/addr1/addr2/in_a/in_b),
// weight ROM (wt_addr/wt_data), result store (store/out_c/w_addr/value).
module layer2_conv_engine #(
  parameter int OC_NUM        = 8,
  parameter int IN_ROW_STRIDE = 56,
  parameter int IN_COL_STRIDE = 2,
  parameter int OUT_DIM       = 12,
  parameter int SHIFT         = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         load,
  output logic [9:0]   addr1,
  output logic [9:0]   addr2,
  input  logic [63:0]  in_a,
  input  logic [63:0]  in_b,
  output logic [6:0]   wt_addr,
  input  logic [127:0] wt_data,
  output logic         store,
  output logic [3:0]   out_c,
  output logic [9:0]   w_addr,
  output logic [7:0]   value
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_OUT,
    S_FIN
  } state_t;

  localparam logic [3:0] LAST_RC = 4'(OUT_DIM - 1);
  localparam logic [3:0] LAST_OC = 4'(OC_NUM - 1);

  state_t state, state_nx;
  logic armed;
  logic [2:0] k;
  logic [3:0] r, c, oc;
  logic signed [21:0] acc, acc_nx, psum, shifted;
  logic signed [15:0] pa, pb;
  logic [7:0] sat;
  logic [3:0] ta, tb, offa, offb;
  logic rd, first_pair, last_pair, mac_en, last_pix;

  // {dr, dc} of tap t within the 3x3 window
  function automatic logic [3:0] tap_off(input logic [3:0] t);
    logic [3:0] o;
    case (t)
      4'd0:    o = 4'b00_00;
      4'd1:    o = 4'b00_01;
      4'd2:    o = 4'b00_10;
      4'd3:    o = 4'b01_00;
      4'd4:    o = 4'b01_01;
      4'd5:    o = 4'b01_10;
      4'd6:    o = 4'b10_00;
      4'd7:    o = 4'b10_01;
      default: o = 4'b10_10;
    endcase
    return o;
  endfunction

  function automatic logic [9:0] tap_addr(
    input logic [3:0] row,
    input logic [3:0] col
  );
    return 10'(row) * 10'(IN_ROW_STRIDE)
         + 10'(col) * 10'(IN_COL_STRIDE);
  endfunction

  assign rd = (state == S_READ);
  assign busy = (state == S_READ) || (state == S_DRAIN)
             || (state == S_OUT);
  assign done = (state == S_FIN);
  assign load = rd;

  // Pair k reads taps 2k and 2k+1; the last pair repeats tap 8.
  assign ta = {k, 1'b0};
  assign tb = (k == 3'd4) ? 4'd8 : {k, 1'b1};
  assign offa = tap_off(ta);
  assign offb = tap_off(tb);

  assign addr1 = rd ? tap_addr(r + {2'b00, offa[3:2]},
                               c + {2'b00, offa[1:0]}) : '0;
  assign addr2 = rd ? tap_addr(r + {2'b00, offb[3:2]},
                               c + {2'b00, offb[1:0]}) : '0;
  assign wt_addr = rd ? 7'(oc) * 7'd5 + 7'(k) : '0;

  // Data for the pair issued last cycle is on the inputs now.
  assign first_pair = rd && (k == 3'd1);
  assign last_pair = (state == S_DRAIN);
  assign mac_en = (rd && (k != 3'd0)) || last_pair;

  always_comb begin
    psum = '0;
    pa = '0;
    pb = '0;
    for (int i = 0; i < 8; i++) begin
      pa = 16'($signed(in_a[8*i +: 8]))
         * 16'($signed(wt_data[8*i +: 8]));
      pb = 16'($signed(in_b[8*i +: 8]))
         * 16'($signed(wt_data[64+8*i +: 8]));
      psum = psum + 22'(pa);
      if (!last_pair) psum = psum + 22'(pb);
    end
  end

  assign acc_nx = first_pair ? psum : acc + psum;
  assign shifted = acc_nx >>> SHIFT;

  always_comb begin
    if (shifted > 22'sd127) sat = 8'h7f;
    else if (shifted < -22'sd128) sat = 8'h80;
    else sat = shifted[7:0];
  end

  assign last_pix = (c == LAST_RC) && (r == LAST_RC)
                 && (oc == LAST_OC);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start && armed) state_nx = S_READ;
      S_READ:  if (k == 3'd4) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_OUT;
      S_OUT:   state_nx = last_pix ? S_FIN : S_READ;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      armed  <= 1'b0;
      k      <= '0;
      r      <= '0;
      c      <= '0;
      oc     <= '0;
      acc    <= '0;
      store  <= 1'b0;
      out_c  <= '0;
      w_addr <= '0;
      value  <= '0;
    end else begin
      state <= state_nx;
      store <= 1'b0;
      if (mac_en) acc <= acc_nx;
      unique case (state)
        S_IDLE: begin
          if (start && armed) begin
            armed <= 1'b0;
            k  <= '0;
            r  <= '0;
            c  <= '0;
            oc <= '0;
          end else if (!start) begin
            armed <= 1'b1;
          end
        end
        S_READ: k <= (k == 3'd4) ? 3'd0 : k + 3'd1;
        S_DRAIN: begin
          // acc_nx already holds the final pair here
          store  <= 1'b1;
          out_c  <= oc;
          w_addr <= 10'(r) * 10'(OUT_DIM) + 10'(c);
          value  <= sat;
        end
        S_OUT: begin
          if (c == LAST_RC) begin
            c <= '0;
            if (r == LAST_RC) begin
              r <= '0;
              if (!last_pix) oc <= oc + 4'd1;
            end else begin
              r <= r + 4'd1;
            end
          end else begin
            c <= c + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer2_conv_engine.sv
// tb_layer2_conv_engine: randomized and directed checks of the layer-2
// convolution engine against an arithmetic reference model.
module tb_layer2_conv_engine;

  localparam int OC_NUM = 8;
  localparam int RS = 56;
  localparam int CS = 2;
  localparam int DIM = 12;
  localparam int SH = 7;
  localparam int NPIX = DIM * DIM * OC_NUM;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy, done, load, store;
  logic [9:0] addr1, addr2, w_addr;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic [6:0] wt_addr;
  logic [127:0] wt_data = '0;
  logic [3:0] out_c;
  logic [7:0] value;

  int checks = 0;
  int errors = 0;

  layer2_conv_engine #(
    .OC_NUM(OC_NUM),
    .IN_ROW_STRIDE(RS),
    .IN_COL_STRIDE(CS),
    .OUT_DIM(DIM),
    .SHIFT(SH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .done(done),
    .load(load),
    .addr1(addr1),
    .addr2(addr2),
    .in_a(in_a),
    .in_b(in_b),
    .wt_addr(wt_addr),
    .wt_data(wt_data),
    .store(store),
    .out_c(out_c),
    .w_addr(w_addr),
    .value(value)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [0:1023];
  logic [127:0] wrom [0:127];

  always @(posedge clk) begin
    if (load) begin
      in_a <= mem[addr1];
      in_b <= mem[addr2];
      wt_data <= wrom[wt_addr];
    end
  end

  typedef struct {
    int cyc;
    logic [9:0] a1;
    logic [9:0] a2;
    logic [6:0] wa;
  } ld_t;

  typedef struct {
    int cyc;
    logic [3:0] oc;
    logic [9:0] wa;
    logic [7:0] v;
  } st_t;

  ld_t ld_q[$];
  st_t st_q[$];
  int done_cyc;
  int done_cnt;
  logic busy0;

  function automatic int tapa(int r, int c, int t);
    return (r + t / 3) * RS + (c + t % 3) * CS;
  endfunction

  function automatic logic [7:0] ref_pix(int oc, int r, int c);
    longint acc;
    longint s;
    byte d, w;
    logic [63:0] dv;
    logic [127:0] wv;
    acc = 0;
    for (int t = 0; t < 9; t++) begin
      dv = mem[tapa(r, c, t)];
      wv = wrom[oc * 5 + t / 2];
      for (int i = 0; i < 8; i++) begin
        d = dv[8*i +: 8];
        w = wv[(t % 2) * 64 + 8 * i +: 8];
        acc += longint'(d) * longint'(w);
      end
    end
    s = acc >>> SH;
    if (s > 127) return 8'h7f;
    if (s < -128) return 8'h80;
    return s[7:0];
  endfunction

  task automatic fill_random();
    for (int a = 0; a < 1024; a++)
      for (int i = 0; i < 8; i++)
        mem[a][8*i +: 8] = 8'($urandom_range(0, 127)) - 8'd64;
    for (int a = 0; a < 128; a++)
      for (int i = 0; i < 16; i++)
        wrom[a][8*i +: 8] = 8'($urandom_range(0, 31)) - 8'd16;
    for (int o = 0; o < OC_NUM; o++)
      wrom[o * 5 + 4][127:64] = 64'h7f7f_7f7f_7f7f_7f7f;
  endtask

  task automatic fill_const(input logic [7:0] d, input logic [7:0] w);
    for (int a = 0; a < 1024; a++) mem[a] = {8{d}};
    for (int a = 0; a < 128; a++) wrom[a] = {16{w}};
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic observe(input int max_cyc, input int stop_st,
                         output bit to);
    ld_q.delete();
    st_q.delete();
    done_cyc = -1;
    done_cnt = 0;
    busy0 = 1'b0;
    to = 1'b1;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      if (n == 0) busy0 = busy;
      if (load) ld_q.push_back('{n, addr1, addr2, wt_addr});
      if (store) st_q.push_back('{n, out_c, w_addr, value});
      if (done) begin
        done_cyc = n;
        done_cnt++;
        to = 1'b0;
        break;
      end
      if (stop_st > 0 && st_q.size() == stop_st) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, load, addr1, addr2, wt_addr, store, out_c,
         w_addr, value} !== 53'd0)
      $display("FAIL reset_outputs got %h want 0",
               {busy, done, load, addr1, addr2, wt_addr, store, out_c,
                w_addr, value});
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || load !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet got busy=%b load=%b want 0 0",
               busy, load);
    end
  endtask

  task automatic test_random_run();
    bit to;
    int bad, first;
    int e1[5];
    int e2[5];
    int pix, oc, r, c, k, n, t2;
    logic [7:0] ev;
    e1 = '{0, 4, 58, 112, 116};
    e2 = '{2, 56, 60, 114, 116};
    fill_random();
    kick();
    observe(9000, 0, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL run_timeout got no done want done");
    end
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start got %b want 1", busy0);
    end
    checks++;
    if (ld_q.size() == 0 || ld_q[0].cyc != 0) begin
      errors++;
      $display("FAIL first_load got %0d loads want load at cycle 0",
               ld_q.size());
    end
    checks++;
    if (done_cyc != 144 * 7 * OC_NUM) begin
      errors++;
      $display("FAIL done_cycle got %0d want %0d",
               done_cyc, 144 * 7 * OC_NUM);
    end
    checks++;
    if (st_q.size() != NPIX) begin
      errors++;
      $display("FAIL store_count got %0d want %0d", st_q.size(), NPIX);
    end
    bad = 0;
    first = -1;
    for (int p = 0; p < st_q.size(); p++) begin
      oc = p / 144;
      pix = p % 144;
      ev = ref_pix(oc, pix / DIM, pix % DIM);
      if (st_q[p].oc !== 4'(oc) || st_q[p].wa !== 10'(pix) ||
          st_q[p].v !== ev || st_q[p].cyc != 7 * p + 6) begin
        bad++;
        if (first < 0) first = p;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL store_stream got %0d bad (first #%0d v=%0d) want 0",
               bad, first, $signed(st_q[first].v));
    end
    checks++;
    if (ld_q.size() != NPIX * 5) begin
      errors++;
      $display("FAIL load_count got %0d want %0d",
               ld_q.size(), NPIX * 5);
    end
    bad = 0;
    first = -1;
    for (int m = 0; m < ld_q.size(); m++) begin
      pix = m / 5;
      k = m % 5;
      oc = pix / 144;
      r = (pix % 144) / DIM;
      c = pix % DIM;
      t2 = (k < 4) ? 2 * k + 1 : 8;
      if (ld_q[m].a1 !== 10'(tapa(r, c, 2 * k)) ||
          ld_q[m].a2 !== 10'(tapa(r, c, t2)) ||
          ld_q[m].wa !== 7'(oc * 5 + k) ||
          ld_q[m].cyc != 7 * pix + k) begin
        bad++;
        if (first < 0) first = m;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL load_stream got %0d bad (first #%0d) want 0",
               bad, first);
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (ld_q.size() <= j) begin
        errors++;
        $display("FAIL pair0_%0d got none want (%0d,%0d)",
                 j, e1[j], e2[j]);
      end else if (ld_q[j].a1 !== 10'(e1[j]) ||
                   ld_q[j].a2 !== 10'(e2[j])) begin
        errors++;
        $display("FAIL pair0_%0d got (%0d,%0d) want (%0d,%0d)", j,
                 ld_q[j].a1, ld_q[j].a2, e1[j], e2[j]);
      end
    end
    n = 143 * 5 + 4;
    checks++;
    if (ld_q.size() <= n) begin
      errors++;
      $display("FAIL pair_11_11 got none want %0d", tapa(11, 11, 8));
    end else if (ld_q[n].a1 !== 10'(tapa(11, 11, 8)) ||
                 ld_q[n].a2 !== 10'(tapa(11, 11, 8))) begin
      errors++;
      $display("FAIL pair_11_11 got (%0d,%0d) want %0d", ld_q[n].a1,
               ld_q[n].a2, tapa(11, 11, 8));
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done got done=%b busy=%b want 0 0",
               done, busy);
    end
  endtask

  task automatic test_hold_start();
    bit to;
    observe(60, 0, to);
    checks++;
    if (ld_q.size() != 0 || st_q.size() != 0 || done_cnt != 0 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_start got loads=%0d stores=%0d want 0 0",
               ld_q.size(), st_q.size());
    end
  endtask

  task automatic test_constant_rerun();
    bit to;
    int bad;
    fill_const(8'd16, 8'd8);
    kick();
    observe(9000, 0, to);
    checks++;
    if (to || st_q.size() != NPIX) begin
      errors++;
      $display("FAIL rerun_count got %0d want %0d", st_q.size(), NPIX);
    end
    bad = 0;
    for (int p = 0; p < st_q.size(); p++)
      if (st_q[p].v !== 8'd72) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL const_value got %0d bad want 0 (value 72)", bad);
    end
    bad = 0;
    for (int p = 0; p < st_q.size(); p++)
      if (st_q[p].wa !== 10'(p % 144) || st_q[p].oc !== 4'(p / 144))
        bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL const_waddr got %0d bad want 0", bad);
    end
  endtask

  task automatic test_saturation();
    bit to;
    logic [7:0] dv[3];
    logic [7:0] wv[3];
    logic [7:0] ev[3];
    dv = '{8'h7f, 8'h7f, 8'h80};
    wv = '{8'h7f, 8'h80, 8'h80};
    ev = '{8'h7f, 8'h80, 8'h7f};
    for (int j = 0; j < 3; j++) begin
      fill_const(dv[j], wv[j]);
      kick();
      observe(100, 1, to);
      checks++;
      if (to || st_q.size() != 1) begin
        errors++;
        $display("FAIL sat_%0d got no store want %0d",
                 j, $signed(ev[j]));
      end else if (st_q[0].v !== ev[j]) begin
        errors++;
        $display("FAIL sat_%0d got %0d want %0d", j,
                 $signed(st_q[0].v), $signed(ev[j]));
      end
      start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
    end
  endtask

  task automatic test_mid_reset();
    bit to;
    fill_random();
    kick();
    observe(2000, 41, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL mid_reach got %0d stores want 41", st_q.size());
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (load !== 1'b1 || addr1 !== 10'(tapa(3, 5, 2)) ||
        addr2 !== 10'(tapa(3, 5, 3))) begin
      errors++;
      $display("FAIL mid_pixel got (%0d,%0d) want (%0d,%0d)", addr1,
               addr2, tapa(3, 5, 2), tapa(3, 5, 3));
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, load, addr1, addr2, wt_addr, store, out_c,
         w_addr, value} !== 53'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %h want 0",
               {busy, done, load, addr1, addr2, wt_addr, store, out_c,
                w_addr, value});
    end
    rst = 1'b1;
    observe(200, 0, to);
    checks++;
    if (st_q.size() != 0 || done_cnt != 0 || ld_q.size() != 0) begin
      errors++;
      $display("FAIL post_abort got stores=%0d done=%0d want 0 0",
               st_q.size(), done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_random_run();
    test_hold_start();
    test_constant_rerun();
    test_saturation();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
